// File: rtl/mole_if.sv
// Game-side bundle for the mole spawner: tick/enable/whack in, hole display
// and per-cycle score counts out. The false_whack_o member exists only when
// MOLE_FALSE_WHACK_PENALTY_EN is defined.
interface mole_if #(
   parameter int NUM_HOLES = 16,
   parameter int MAX_MOLES = 2
);
   localparam int CW = $clog2(MAX_MOLES + 1);

   logic                 tick_i;
   logic                 enable_i;
   logic [NUM_HOLES-1:0] whack_i;
   logic [NUM_HOLES-1:0] mole_o;
   logic [CW-1:0]        hit_count_o;
   logic [CW-1:0]        miss_count_o;
   logic [CW-1:0]        active_count_o;
`ifdef MOLE_FALSE_WHACK_PENALTY_EN
   logic                 false_whack_o;

   modport slave (
      input  tick_i, enable_i, whack_i,
      output mole_o, hit_count_o, miss_count_o, active_count_o, false_whack_o
   );
   modport master (
      output tick_i, enable_i, whack_i,
      input  mole_o, hit_count_o, miss_count_o, active_count_o, false_whack_o
   );
`else
   modport slave (
      input  tick_i, enable_i, whack_i,
      output mole_o, hit_count_o, miss_count_o, active_count_o
   );
   modport master (
      output tick_i, enable_i, whack_i,
      input  mole_o, hit_count_o, miss_count_o, active_count_o
   );
`endif
endinterface

// File: rtl/mole_spawner.sv
// Mole-location engine: MAX_MOLES slots cycling EMPTY -> UP -> COOLDOWN,
// holes picked from a free-running 16-bit Galois LFSR, registered per-cycle
// hit/miss counts for the score logic and a hole display vector.
// Optional macro MOLE_FALSE_WHACK_PENALTY_EN adds a registered false_whack_o
// pulse when any whack lands on a hole with no mole up.
module mole_spawner #(
   parameter int          NUM_HOLES  = 16,
   parameter int          MAX_MOLES  = 2,
   parameter int          LIFE_TICKS = 8,
   parameter int          GAP_TICKS  = 2,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input logic   clock_i,
   input logic   reset_i,
   mole_if.slave bus
);
   localparam int          HW     = (NUM_HOLES > 1) ? $clog2(NUM_HOLES) : 1;
   localparam int          CW     = $clog2(MAX_MOLES + 1);
   localparam logic [7:0]  LIFE_T = 8'(LIFE_TICKS);
   localparam logic [7:0]  GAP_T  = 8'(GAP_TICKS);
   // x^16+x^14+x^13+x^11 in right-shifting Galois form
   localparam logic [15:0] TAPS   = 16'hB400;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_UP    = 2'd1,
      S_COOL  = 2'd2
   } slot_state_e;

   slot_state_e          state_q [MAX_MOLES];
   slot_state_e          state_d [MAX_MOLES];
   logic [7:0]           timer_q [MAX_MOLES];
   logic [7:0]           timer_d [MAX_MOLES];
   logic [HW-1:0]        hole_q  [MAX_MOLES];
   logic [HW-1:0]        hole_d  [MAX_MOLES];
   logic [15:0]          lfsr_q;
   logic [15:0]          lfsr_d;
   logic [CW-1:0]        hit_q;
   logic [CW-1:0]        hit_d;
   logic [CW-1:0]        miss_q;
   logic [CW-1:0]        miss_d;

   logic [NUM_HOLES-1:0] slot_onehot [MAX_MOLES];
   logic [MAX_MOLES-1:0] slot_up;
   logic [MAX_MOLES-1:0] slot_whacked;
   logic [MAX_MOLES-1:0] slot_clash;
   logic [NUM_HOLES-1:0] mole_vec;
   logic [CW-1:0]        active_sum;
   logic [HW-1:0]        cand_hole;
   logic                 tick_en;

   assign tick_en   = bus.tick_i & bus.enable_i;
   assign cand_hole = HW'(lfsr_q % 16'(NUM_HOLES));
   assign lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);

   // Per-slot decode from registered state only
   genvar gi;
   generate
      for (gi = 0; gi < MAX_MOLES; gi++) begin : g_slot
         assign slot_up[gi]      = (state_q[gi] == S_UP);
         assign slot_onehot[gi]  = slot_up[gi] ? (NUM_HOLES'(1) << hole_q[gi]) : '0;
         assign slot_whacked[gi] = slot_up[gi] & bus.whack_i[hole_q[gi]];
         assign slot_clash[gi]   = slot_up[gi] & (hole_q[gi] == cand_hole);
      end
   endgenerate

   // State register: slots, LFSR and the one-cycle event counts
   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         for (int s = 0; s < MAX_MOLES; s++) begin
            state_q[s] <= S_EMPTY;
            timer_q[s] <= '0;
            hole_q[s]  <= '0;
         end
         lfsr_q <= LFSR_SEED;
         hit_q  <= '0;
         miss_q <= '0;
      end else begin
         for (int s = 0; s < MAX_MOLES; s++) begin
            state_q[s] <= state_d[s];
            timer_q[s] <= timer_d[s];
            hole_q[s]  <= hole_d[s];
         end
         lfsr_q <= lfsr_d;
         hit_q  <= hit_d;
         miss_q <= miss_d;
      end
   end

   // Next state: whack beats escape, cooldown expiry, one spawn per enabled tick
   always_comb begin
      logic empty_seen;
      empty_seen = 1'b0;
      hit_d      = '0;
      miss_d     = '0;
      for (int s = 0; s < MAX_MOLES; s++) begin
         state_d[s] = state_q[s];
         timer_d[s] = timer_q[s];
         hole_d[s]  = hole_q[s];
         case (state_q[s])
            S_EMPTY: begin
               // Only the lowest free slot may claim the candidate; a clash
               // with a live mole cancels the spawn for this tick entirely.
               if (!empty_seen) begin
                  empty_seen = 1'b1;
                  if (tick_en && !(|slot_clash)) begin
                     state_d[s] = S_UP;
                     timer_d[s] = LIFE_T;
                     hole_d[s]  = cand_hole;
                  end
               end
            end
            S_UP: begin
               if (slot_whacked[s]) begin
                  state_d[s] = S_COOL;
                  timer_d[s] = GAP_T;
                  hit_d      = hit_d + CW'(1);
               end else if (tick_en) begin
                  if (timer_q[s] == 8'd1) begin
                     state_d[s] = S_COOL;
                     timer_d[s] = GAP_T;
                     miss_d     = miss_d + CW'(1);
                  end else begin
                     timer_d[s] = timer_q[s] - 8'd1;
                  end
               end
            end
            S_COOL: begin
               // Expiry at zero needs no tick, so a zero gap frees the slot
               // on the very next clock.
               if (timer_q[s] == 8'd0) begin
                  state_d[s] = S_EMPTY;
               end else if (tick_en) begin
                  timer_d[s] = timer_q[s] - 8'd1;
               end
            end
            default: begin
               state_d[s] = S_EMPTY;
               timer_d[s] = '0;
            end
         endcase
      end
   end

   // Outputs: display vector and live-mole count from registered slot state
   always_comb begin
      mole_vec   = '0;
      active_sum = '0;
      for (int s = 0; s < MAX_MOLES; s++) begin
         mole_vec   = mole_vec | slot_onehot[s];
         active_sum = active_sum + CW'(slot_up[s]);
      end
   end

   assign bus.mole_o         = mole_vec;
   assign bus.hit_count_o    = hit_q;
   assign bus.miss_count_o   = miss_q;
   assign bus.active_count_o = active_sum;

`ifdef MOLE_FALSE_WHACK_PENALTY_EN
   logic false_whack_q;

   // Single pulse when any whack bit lands on an empty hole
   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         false_whack_q <= 1'b0;
      end else begin
         false_whack_q <= |(bus.whack_i & ~mole_vec);
      end
   end

   assign bus.false_whack_o = false_whack_q;
`endif

endmodule
